// File: rtl/seq_divider.sv
// Unsigned restoring divider: DW-bit dividend / VW-bit divisor -> quotient, remainder.
// Latency: DW+1 cycles from accepted start to done (1 cycle for divide-by-zero).
// Backpressure: none; start is ignored while busy, results hold until the next completion.
module seq_divider #(
  parameter int DW = 24,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dq;       // dividend bits shift out at the top, quotient bits shift in at the bottom
  logic [VW:0]   part;     // one spare bit so the shifted value never overflows the compare
  logic [VW-1:0] dvs;
  logic          accept;
  logic          last;
  logic [VW:0]   shifted;
  logic [VW:0]   diff;
  logic          qbit;
  logic [VW:0]   part_nx;
  logic [DW-1:0] dq_nx;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = (part << 1) | {{VW{1'b0}}, dq[DW-1]};
    diff    = shifted - {1'b0, dvs};
    qbit    = (shifted >= {1'b0, dvs});
    part_nx = qbit ? diff : shifted;
    dq_nx   = {dq[DW-2:0], qbit};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs; a zero divisor skips RUN entirely.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = (divisor == '0) ? DONE : RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture on accept, then one iteration per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq   <= '0;
      part <= '0;
      dvs  <= '0;
      cnt  <= '0;
    end else if (accept) begin
      dq   <= dividend;
      part <= '0;
      dvs  <= divisor;
      cnt  <= '0;
    end else if (state == RUN) begin
      dq   <= dq_nx;
      part <= part_nx;
      cnt  <= cnt + CW'(1);
    end
  end

  // Results load only on the edge entering DONE and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && divisor == '0) begin
      quotient    <= '1;
      remainder   <= dividend[VW-1:0];
      div_by_zero <= 1'b1;
    end else if (last) begin
      quotient    <= dq_nx;
      remainder   <= part_nx[VW-1:0];
      div_by_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector and randomised bench for seq_divider.
// Checks results, start-to-done latency, busy length and done pulse count.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_seq_divider;
  localparam int DW = 24;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, done, div_by_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  int total = 0;
  int bad = 0;
  int nops = 0;
  int ndone = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
  } vec_t;

  vec_t tbl[11];

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) ndone++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Launch one division and wait for done; glitch>0 pulses start at that RUN cycle.
  task automatic do_div(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit b2b,
                        input int glitch, output logic [DW-1:0] q, output logic [VW-1:0] r,
                        output logic z);
    int lat;
    int nbusy;
    if (!b2b) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    lat   = 1;
    nbusy = 0;
    while (!done && lat < 64) begin
      if (busy) nbusy++;
      start = (lat == glitch);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    nops++;
    chk("latency", lat, (b == '0) ? 1 : DW + 1);
    chk("busy_cycles", nbusy, (b == '0) ? 0 : DW);
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  initial begin
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
    int            seen;

    tbl[0]  = '{24'd1000,     8'd7,   24'd142,     8'd6,    1'b0};
    tbl[1]  = '{24'hFFFFFF,   8'hFF,  24'h010101,  8'd0,    1'b0};
    tbl[2]  = '{24'hFFFFFF,   8'd1,   24'hFFFFFF,  8'd0,    1'b0};
    tbl[3]  = '{24'd12345,    8'd0,   24'hFFFFFF,  8'h39,   1'b1};
    tbl[4]  = '{24'd50,       8'd5,   24'd10,      8'd0,    1'b0};
    tbl[5]  = '{24'd0,        8'd9,   24'd0,       8'd0,    1'b0};
    tbl[6]  = '{24'd9,        8'd10,  24'd0,       8'd9,    1'b0};
    tbl[7]  = '{24'd100,      8'd3,   24'd33,      8'd1,    1'b0};
    tbl[8]  = '{24'd255,      8'd16,  24'd15,      8'd15,   1'b0};
    tbl[9]  = '{24'h800000,   8'h80,  24'h010000,  8'd0,    1'b0};
    tbl[10] = '{24'd123456,   8'd200, 24'd617,     8'd56,   1'b0};

    // Reset state.
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      do_div(tbl[i].a, tbl[i].b, 1'b0, 0, q, r, z);
      chk($sformatf("tbl%0d_q", i), q, tbl[i].q);
      chk($sformatf("tbl%0d_r", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_dbz", i), z, tbl[i].z);
      @(negedge clk);
      chk($sformatf("tbl%0d_done_pulse", i), done, 0);
    end

    // Back-to-back start in the DONE cycle.
    do_div(24'd100, 8'd3, 1'b0, 0, q, r, z);
    chk("b2b_first_q", q, 33);
    chk("b2b_first_r", r, 1);
    do_div(24'd9, 8'd10, 1'b1, 0, q, r, z);
    chk("b2b_second_q", q, 0);
    chk("b2b_second_r", r, 9);

    // Start pulsed mid-RUN must be ignored.
    do_div(24'd1000, 8'd7, 1'b0, 5, q, r, z);
    chk("glitch_q", q, 142);
    chk("glitch_r", r, 6);

    // Reset mid-division clears everything and produces no done.
    @(negedge clk);
    dividend = 24'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_q", quotient, 0);
    chk("midrst_r", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("post_reset_idle", seen, 0);

    // Random operands with random gaps, checked against the division identity.
    for (int i = 0; i < 1000; i++) begin
      logic [DW-1:0] a;
      logic [VW-1:0] b;
      int            gap;
      bit            ok;
      a = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 300)) : DW'($urandom);
      b = ($urandom_range(0, 49) == 0) ? '0 : VW'($urandom_range(1, 255));
      gap = $urandom_range(0, 3);
      if (gap > 1) repeat (gap - 1) @(negedge clk);
      do_div(a, b, (gap == 0 && i > 0), 0, q, r, z);
      if (b == '0)
        ok = (q == '1) && (r == a[VW-1:0]) && z;
      else
        ok = ((longint'(q) * longint'(b) + longint'(r)) == longint'(a)) && (r < b) && !z;
      chk($sformatf("rand%0d_%0d_div_%0d", i, a, b), ok, 1);
    end

    @(negedge clk);
    @(negedge clk);
    chk("done_count", ndone, nops);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider; performs the inverse operation of the multiply-accumulate block.
- Takes an accumulated sum (e.g. a 24-bit MAC result) and a divisor, and produces quotient and remainder, one quotient bit per clock.
- Sits downstream of accumulators in the arithmetic datapath, e.g. for averaging and normalisation.
- Uses a start/busy/done handshake with the requesting controller.

Parameters:
- DW, 24, dividend and quotient width in bits (≥2).
- VW, 8, divisor and remainder width in bits (1..DW).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  DW  unsigned dividend; captured when start is accepted.
- divisor  input  VW  unsigned divisor; captured when start is accepted.
- busy  output  1  high while division is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  DW  unsigned quotient.
- remainder  output  VW  unsigned remainder.
- div_by_zero  output  1  set with results if the captured divisor was 0.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - State goes to IDLE.
  - busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
  - Internal shift and partial-remainder registers are cleared.
  - Reset mid-division abandons the operation with no done pulse.
- States:
  - IDLE: wait for start.
  - RUN: iterate.
  - DONE: single cycle; done=1.
- Transitions:
  - IDLE/DONE --start=1--> RUN. Operands are captured in the same edge, and busy=1 from the next cycle.
  - IDLE/DONE --start=1 with divisor==0--> DONE directly.
  - RUN --after DW iterations--> DONE.
  - DONE --start=0--> IDLE.
  - start during RUN is ignored; no queueing and no restart.
  - start while in DONE is accepted (back-to-back), so done and the new busy are never high in the same cycle.
- Iteration (RUN): each cycle shifts one dividend bit (MSB first) into the partial remainder.
  - The partial remainder register is VW+1 bits wide so the compare/subtract cannot overflow.
  - If partial ≥ divisor: subtract, and the quotient bit is 1. Otherwise the quotient bit is 0.
- Latency:
  - start accepted at edge N, done=1 during cycle N+DW+1, busy=1 for exactly DW cycles.
  - Divide-by-zero: done=1 during cycle N+1, busy never asserts.
- Results:
  - quotient/remainder update only on the edge entering DONE.
  - They hold stable afterwards until the next completion or reset, including through IDLE and the next RUN.
  - Invariant: quotient*divisor + remainder == dividend, with remainder < divisor.
- Divide-by-zero: quotient = all ones, remainder = low VW bits of dividend, div_by_zero=1.
  - div_by_zero is updated on every completion and cleared by a subsequent non-zero division.
- Boundary cases:
  - dividend=0 gives quotient=0, remainder=0 after the full DW cycles (no early exit).
  - divisor=1 gives quotient=dividend, remainder=0.
  - dividend < divisor gives quotient=0, remainder=dividend.
- Operand changes on the dividend/divisor pins after capture have no effect on the operation in flight.

Test Plan:
- Reset check: assert rst_n=0 during RUN of 1000/7 → busy, done, quotient, remainder and div_by_zero are all 0 immediately. After release, no done pulse occurs and the block stays in IDLE.
- Basic division: 24'd1000 / 8'd7 → after 24 busy cycles, done pulses once with quotient=142, remainder=6, div_by_zero=0.
- Maximum operands:
  - 24'hFFFFFF / 8'hFF → quotient=24'h010101, remainder=0.
  - 24'hFFFFFF / 8'd1 → quotient=24'hFFFFFF, remainder=0.
- Divide-by-zero: 24'd12345 / 8'd0 → done pulses the cycle after start, busy stays 0, quotient=24'hFFFFFF, remainder=8'h39, div_by_zero=1. A following 50/5 returns quotient=10, remainder=0, div_by_zero=0.
- Handshake robustness: pulse start again mid-RUN with different operands → the pulse is ignored and the original result is returned. Assert start in the DONE cycle (100/3, then 9/10) → the second run starts immediately and returns quotient=0, remainder=9.
- Randomised self-check: 1000 random operand pairs with random start gaps → every result satisfies q*d + r == dividend and r < d, and every start accepted in IDLE/DONE yields exactly one done pulse.
